// File: rtl/maze_pkg.sv
// maze_pkg: shared maze geometry, checkpoint tile indices and the loader FSM
// state type, imported by maze_rom and maze_state_writer.
package maze_pkg;

   localparam int unsigned MAZE_COLS  = 18;
   localparam int unsigned MAZE_ROWS  = 11;
   localparam int unsigned MAZE_TILES = 198;

   localparam int unsigned COL_W = 5;
   localparam int unsigned ROW_W = 4;
   localparam int unsigned IDX_W = 8;
   localparam int unsigned LVL_W = 2;

   // Checkpoint tiles are fixed by the level design and never player-editable.
   localparam logic [IDX_W-1:0] CP_IDX_0 = 8'd31;
   localparam logic [IDX_W-1:0] CP_IDX_1 = 8'd37;
   localparam logic [IDX_W-1:0] CP_IDX_2 = 8'd113;
   localparam logic [IDX_W-1:0] CP_IDX_3 = 8'd139;
   localparam logic [IDX_W-1:0] CP_IDX_4 = 8'd178;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   function automatic logic is_checkpoint(input logic [IDX_W-1:0] idx);
      return (idx == CP_IDX_0) || (idx == CP_IDX_1) || (idx == CP_IDX_2) ||
             (idx == CP_IDX_3) || (idx == CP_IDX_4);
   endfunction

endpackage

// File: rtl/maze_rom.sv
// maze_rom: 4 mazes x 11 rows of 18-bit tile words; bit 0 = column 0.
// Ports: CLK (clock), level (maze select), row (row select, 11..15 read 0),
//        row_word (registered row data, 1-cycle latency).
module maze_rom
   import maze_pkg::*;
(
   input  logic                 CLK,
   input  logic [LVL_W-1:0]     level,
   input  logic [ROW_W-1:0]     row,
   output logic [MAZE_COLS-1:0] row_word
);

   logic [MAZE_COLS-1:0] row_word_d;
   logic [MAZE_COLS-1:0] row_word_q;

   // Maze table lookup.
   always_comb begin
      row_word_d = '0;
      case ({level, row})
         // level 0
         6'h00: row_word_d = 18'h3FFFF;
         6'h01: row_word_d = 18'h20001;
         6'h02: row_word_d = 18'h2FFFD;
         6'h03: row_word_d = 18'h28005;
         6'h04: row_word_d = 18'h2BFF5;
         6'h05: row_word_d = 18'h2A015;
         6'h06: row_word_d = 18'h2AFD5;
         6'h07: row_word_d = 18'h28055;
         6'h08: row_word_d = 18'h2FF5D;
         6'h09: row_word_d = 18'h20001;
         6'h0A: row_word_d = 18'h3FFFF;
         // level 1
         6'h10: row_word_d = 18'h15555;
         6'h11: row_word_d = 18'h2AAAA;
         6'h12: row_word_d = 18'h15555;
         6'h13: row_word_d = 18'h2AAAA;
         6'h14: row_word_d = 18'h15555;
         6'h15: row_word_d = 18'h2AAAA;
         6'h16: row_word_d = 18'h15555;
         6'h17: row_word_d = 18'h2AAAA;
         6'h18: row_word_d = 18'h15555;
         6'h19: row_word_d = 18'h2AAAA;
         6'h1A: row_word_d = 18'h15555;
         // level 2
         6'h20: row_word_d = 18'h20F0F;
         6'h21: row_word_d = 18'h1F0F0;
         6'h22: row_word_d = 18'h3C3C3;
         6'h23: row_word_d = 18'h03C3C;
         6'h24: row_word_d = 18'h33333;
         6'h25: row_word_d = 18'h0CCCC;
         6'h26: row_word_d = 18'h3F00F;
         6'h27: row_word_d = 18'h00FF0;
         6'h28: row_word_d = 18'h2D2D2;
         6'h29: row_word_d = 18'h12D2D;
         6'h2A: row_word_d = 18'h3E01F;
         // level 3
         6'h30: row_word_d = 18'h00000;
         6'h31: row_word_d = 18'h00001;
         6'h32: row_word_d = 18'h00003;
         6'h33: row_word_d = 18'h00007;
         6'h34: row_word_d = 18'h0000F;
         6'h35: row_word_d = 18'h0001F;
         6'h36: row_word_d = 18'h0003F;
         6'h37: row_word_d = 18'h0007F;
         6'h38: row_word_d = 18'h000FF;
         6'h39: row_word_d = 18'h001FF;
         6'h3A: row_word_d = 18'h003FF;
         default: row_word_d = '0;
      endcase
   end

   // Registered ROM output.
   always_ff @(posedge CLK) begin
      row_word_q <= row_word_d;
   end

   assign row_word = row_word_q;

endmodule

// File: rtl/maze_state_writer.sv
// maze_state_writer: holds the 198-bit tile bitmap read by the OLED maze
// renderer, loads a stored maze row by row on request and, when built with
// MAZE_EDIT_EN, lets the player move a cursor and toggle non-checkpoint tiles.
// Ports: CLK, RESET (sync, active high), load_req/level (load request and maze
//        select), btn_up/down/left/right/toggle (cursor and edit pulses),
//        mazestate (tile bitmap), cursor_idx (cursor tile), busy (load running),
//        done (one-cycle pulse after the last row is written).
// Configuration: `define MAZE_EDIT_EN to build the cursor/toggle logic.
module maze_state_writer
   import maze_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  load_req,
   input  logic [LVL_W-1:0]      level,
   input  logic                  btn_up,
   input  logic                  btn_down,
   input  logic                  btn_left,
   input  logic                  btn_right,
   input  logic                  btn_toggle,
   output logic [MAZE_TILES-1:0] mazestate,
   output logic [IDX_W-1:0]      cursor_idx,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAZE_ROWS - 1);

   state_e                state_q,     state_d;
   logic [LVL_W-1:0]      level_q,     level_d;
   logic [ROW_W-1:0]      rd_row_q,    rd_row_d;
   logic [ROW_W-1:0]      wr_row_q,    wr_row_d;
   logic                  wr_vld_q,    wr_vld_d;
   logic [MAZE_TILES-1:0] mazestate_q, mazestate_d;
   logic                  busy_q,      busy_d;
   logic                  done_q,      done_d;
   logic [MAZE_COLS-1:0]  rom_word;
   logic [IDX_W-1:0]      wr_base_c;

   maze_rom u_rom (
      .CLK      (CLK),
      .level    (level_q),
      .row      (rd_row_q),
      .row_word (rom_word)
   );

   // ROM data lags the row address by one cycle, so the write row is delayed too.
   assign wr_base_c = IDX_W'(wr_row_q) * IDX_W'(MAZE_COLS);

`ifdef MAZE_EDIT_EN
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [IDX_W-1:0] cursor_idx_q, cursor_idx_d;
`else
   logic unused_btn;
   assign unused_btn = ^{btn_up, btn_down, btn_left, btn_right, btn_toggle};
`endif

   // Next-state, row write and edit logic.
   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      rd_row_d    = rd_row_q;
      wr_row_d    = rd_row_q;
      wr_vld_d    = 1'b0;
      mazestate_d = mazestate_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
`ifdef MAZE_EDIT_EN
      col_d       = col_q;
      row_d       = row_q;
`endif

      if (wr_vld_q) begin
         mazestate_d[wr_base_c +: MAZE_COLS] = rom_word;
      end

      case (state_q)
         ST_IDLE: begin
            if (load_req) begin
               state_d  = ST_LOAD;
               level_d  = level;
               rd_row_d = '0;
               busy_d   = 1'b1;
            end
`ifdef MAZE_EDIT_EN
            // Toggle uses the pre-move cursor; checkpoints stay fixed.
            if (btn_toggle && !is_checkpoint(cursor_idx_q)) begin
               mazestate_d[cursor_idx_q] = ~mazestate_q[cursor_idx_q];
            end
            // Opposing pairs cancel; moves saturate at the maze edges.
            if (btn_up && !btn_down && (row_q != '0)) begin
               row_d = row_q - ROW_W'(1);
            end else if (btn_down && !btn_up && (row_q != LAST_ROW)) begin
               row_d = row_q + ROW_W'(1);
            end
            if (btn_left && !btn_right && (col_q != '0)) begin
               col_d = col_q - COL_W'(1);
            end else if (btn_right && !btn_left && (col_q != COL_W'(MAZE_COLS - 1))) begin
               col_d = col_q + COL_W'(1);
            end
`endif
         end
         ST_LOAD: begin
            wr_vld_d = 1'b1;
            if (rd_row_q == LAST_ROW) begin
               state_d = ST_FLUSH;
            end else begin
               rd_row_d = rd_row_q + ROW_W'(1);
            end
         end
         ST_FLUSH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

`ifdef MAZE_EDIT_EN
   assign cursor_idx_d = IDX_W'(col_d) + (IDX_W'(row_d) * IDX_W'(MAZE_COLS));
`endif

   // State and output registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= ST_IDLE;
         level_q      <= '0;
         rd_row_q     <= '0;
         wr_row_q     <= '0;
         wr_vld_q     <= 1'b0;
         mazestate_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef MAZE_EDIT_EN
         col_q        <= '0;
         row_q        <= '0;
         cursor_idx_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         level_q      <= level_d;
         rd_row_q     <= rd_row_d;
         wr_row_q     <= wr_row_d;
         wr_vld_q     <= wr_vld_d;
         mazestate_q  <= mazestate_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
`ifdef MAZE_EDIT_EN
         col_q        <= col_d;
         row_q        <= row_d;
         cursor_idx_q <= cursor_idx_d;
`endif
      end
   end

   assign mazestate = mazestate_q;
   assign busy      = busy_q;
   assign done      = done_q;
`ifdef MAZE_EDIT_EN
   assign cursor_idx = cursor_idx_q;
`else
   assign cursor_idx = '0;
`endif

endmodule

// File: tb/tb_maze_state_writer.sv
// tb_maze_state_writer: directed, self-checking bench for maze_state_writer.
// Cursor/toggle scenarios are built when MAZE_EDIT_EN is defined; otherwise
// the bench checks that the buttons have no effect.
module tb_maze_state_writer;

   logic         CLK = 1'b0;
   logic         RESET = 1'b0;
   logic         load_req = 1'b0;
   logic [1:0]   level = 2'd0;
   logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic         btn_toggle = 1'b0;
   logic [197:0] mazestate;
   logic [7:0]   cursor_idx;
   logic         busy;
   logic         done;

   int           errors = 0;
   int           checks = 0;
   logic [197:0] exp_img;

   always #5 CLK = ~CLK;

   maze_state_writer dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .load_req   (load_req),
      .level      (level),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_toggle (btn_toggle),
      .mazestate  (mazestate),
      .cursor_idx (cursor_idx),
      .busy       (busy),
      .done       (done)
   );

   // Expected maze images, row 10 first in the concatenation.
   function automatic logic [197:0] img(input int lvl);
      case (lvl)
         0: return {18'h3FFFF, 18'h20001, 18'h2FF5D, 18'h28055, 18'h2AFD5, 18'h2A015,
                    18'h2BFF5, 18'h28005, 18'h2FFFD, 18'h20001, 18'h3FFFF};
         1: return {18'h15555, 18'h2AAAA, 18'h15555, 18'h2AAAA, 18'h15555, 18'h2AAAA,
                    18'h15555, 18'h2AAAA, 18'h15555, 18'h2AAAA, 18'h15555};
         2: return {18'h3E01F, 18'h12D2D, 18'h2D2D2, 18'h00FF0, 18'h3F00F, 18'h0CCCC,
                    18'h33333, 18'h03C3C, 18'h3C3C3, 18'h1F0F0, 18'h20F0F};
         default: return {18'h003FF, 18'h001FF, 18'h000FF, 18'h0007F, 18'h0003F, 18'h0001F,
                          18'h0000F, 18'h00007, 18'h00003, 18'h00001, 18'h00000};
      endcase
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic press(input logic u, input logic d, input logic l, input logic r,
                        input logic t);
      btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_toggle = t;
      tick();
      btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_toggle = 0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
      checks++; if (mazestate !== '0) begin errors++; $display("FAIL reset_maze: got %h want 0", mazestate); end
      checks++; if (cursor_idx !== 8'd0) begin errors++; $display("FAIL reset_cursor: got %0d want 0", cursor_idx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
   endtask

   task automatic test_load();
      int n_busy, n_done, done_at;
      level = 2'd2;
      load_req = 1'b1;
      tick();                               // E0
      load_req = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy_e0: got %b want 1", busy); end
      n_busy = 1; n_done = 0; done_at = -1;
      for (int i = 1; i <= 13; i++) begin
         tick();
         if (busy === 1'b1) n_busy++;
         if (done === 1'b1) begin n_done++; done_at = i; end
      end
      checks++; if (n_busy !== 12) begin errors++; $display("FAIL load_busy_cycles: got %0d want 12", n_busy); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL load_done_count: got %0d want 1", n_done); end
      checks++; if (done_at !== 12) begin errors++; $display("FAIL load_done_edge: got E%0d want E12", done_at); end
      exp_img = img(2);
      checks++; if (mazestate !== exp_img) begin errors++; $display("FAIL load_image_l2: got %h want %h", mazestate, exp_img); end
   endtask

   task automatic test_level_latch();
      int n_done;
      level = 2'd0;
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      repeat (14) tick();
      exp_img = img(0);
      checks++; if (mazestate !== exp_img) begin errors++; $display("FAIL latch_image_l0: got %h want %h", mazestate, exp_img); end
      // Reload level 2; change level, retrigger and press a button mid-load.
      level = 2'd2;
      load_req = 1'b1;
      tick();                               // E0
      load_req = 1'b0;
      n_done = 0;
      for (int i = 1; i <= 16; i++) begin
         if (i == 3) level = 2'd0;
         if (i == 4) btn_right = 1'b1;
         if (i == 5) load_req = 1'b1;
         tick();
         load_req = 1'b0;
         btn_right = 1'b0;
         if (done === 1'b1) n_done++;
      end
      exp_img = img(2);
      checks++; if (mazestate !== exp_img) begin errors++; $display("FAIL latch_image_l2: got %h want %h", mazestate, exp_img); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL latch_done_count: got %0d want 1", n_done); end
      checks++; if (cursor_idx !== 8'd0) begin errors++; $display("FAIL latch_btn_dropped: got %0d want 0", cursor_idx); end
   endtask

`ifdef MAZE_EDIT_EN
   task automatic test_cursor();
      repeat (20) press(0, 0, 0, 1, 0);
      checks++; if (cursor_idx !== 8'd17) begin errors++; $display("FAIL cur_right_sat: got %0d want 17", cursor_idx); end
      repeat (15) press(0, 1, 0, 0, 0);
      checks++; if (cursor_idx !== 8'd197) begin errors++; $display("FAIL cur_bottom_right: got %0d want 197", cursor_idx); end
      repeat (25) press(0, 0, 1, 0, 0);
      repeat (12) press(1, 0, 0, 0, 0);
      checks++; if (cursor_idx !== 8'd0) begin errors++; $display("FAIL cur_top_left: got %0d want 0", cursor_idx); end
      repeat (2) press(0, 0, 0, 1, 0);
      repeat (2) press(0, 1, 0, 0, 0);
      checks++; if (cursor_idx !== 8'd38) begin errors++; $display("FAIL cur_mid: got %0d want 38", cursor_idx); end
      press(1, 1, 0, 0, 0);
      press(0, 0, 1, 1, 0);
      checks++; if (cursor_idx !== 8'd38) begin errors++; $display("FAIL cur_cancel: got %0d want 38", cursor_idx); end
      press(1, 0, 0, 1, 0);
      checks++; if (cursor_idx !== 8'd21) begin errors++; $display("FAIL cur_diag_ur: got %0d want 21", cursor_idx); end
      press(0, 1, 1, 0, 0);
      checks++; if (cursor_idx !== 8'd38) begin errors++; $display("FAIL cur_diag_dl: got %0d want 38", cursor_idx); end
      repeat (2) press(0, 0, 1, 0, 0);
      repeat (2) press(1, 0, 0, 0, 0);
      checks++; if (cursor_idx !== 8'd0) begin errors++; $display("FAIL cur_home: got %0d want 0", cursor_idx); end
      checks++; if (mazestate !== exp_img) begin errors++; $display("FAIL cur_no_edit: got %h want %h", mazestate, exp_img); end
   endtask

   task automatic test_toggle();
      repeat (5) press(0, 0, 0, 1, 0);
      repeat (3) press(0, 1, 0, 0, 0);
      checks++; if (cursor_idx !== 8'd59) begin errors++; $display("FAIL tog_pos: got %0d want 59", cursor_idx); end
      press(0, 0, 0, 0, 1);
      exp_img[59] = ~exp_img[59];
      checks++; if (mazestate !== exp_img) begin errors++; $display("FAIL tog_first: got %h want %h", mazestate, exp_img); end
      press(0, 0, 0, 0, 1);
      exp_img[59] = ~exp_img[59];
      checks++; if (mazestate !== exp_img) begin errors++; $display("FAIL tog_restore: got %h want %h", mazestate, exp_img); end
      press(0, 0, 0, 1, 1);
      exp_img[59] = ~exp_img[59];
      checks++; if (mazestate !== exp_img) begin errors++; $display("FAIL tog_with_move: got %h want %h", mazestate, exp_img); end
      checks++; if (cursor_idx !== 8'd60) begin errors++; $display("FAIL tog_move_pos: got %0d want 60", cursor_idx); end
   endtask

   task automatic test_checkpoint();
      repeat (7) press(0, 0, 0, 1, 0);
      repeat (2) press(1, 0, 0, 0, 0);
      checks++; if (cursor_idx !== 8'd31) begin errors++; $display("FAIL cp_pos: got %0d want 31", cursor_idx); end
      press(0, 0, 0, 0, 1);
      checks++; if (mazestate !== exp_img) begin errors++; $display("FAIL cp_protect: got %h want %h", mazestate, exp_img); end
      press(0, 0, 0, 1, 0);
      press(0, 0, 0, 0, 1);
      exp_img[32] = ~exp_img[32];
      checks++; if (mazestate !== exp_img) begin errors++; $display("FAIL cp_neighbor: got %h want %h", mazestate, exp_img); end
   endtask
`else
   task automatic test_no_edit();
      repeat (3) press(0, 0, 0, 1, 0);
      repeat (3) press(0, 1, 0, 0, 0);
      press(0, 0, 0, 0, 1);
      press(1, 0, 1, 0, 1);
      checks++; if (cursor_idx !== 8'd0) begin errors++; $display("FAIL noedit_cursor: got %0d want 0", cursor_idx); end
      checks++; if (mazestate !== exp_img) begin errors++; $display("FAIL noedit_maze: got %h want %h", mazestate, exp_img); end
   endtask
`endif

   task automatic test_reset_midload();
      int n_done, n_busy;
      level = 2'd1;
      load_req = 1'b1;
      tick();                               // E0
      load_req = 1'b0;
      for (int i = 1; i <= 5; i++) tick();
      RESET = 1'b1;
      tick();                               // E6
      RESET = 1'b0;
      checks++; if (mazestate !== '0) begin errors++; $display("FAIL rst_mid_maze: got %h want 0", mazestate); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
      checks++; if (cursor_idx !== 8'd0) begin errors++; $display("FAIL rst_mid_cursor: got %0d want 0", cursor_idx); end
      n_done = 0; n_busy = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done === 1'b1) n_done++;
         if (busy === 1'b1) n_busy++;
      end
      checks++; if (n_done !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d want 0", n_done); end
      checks++; if (mazestate !== '0) begin errors++; $display("FAIL rst_mid_stays_clear: got %h want 0", mazestate); end
      // FSM must be idle: a fresh request is accepted immediately.
      level = 2'd3;
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_reaccept: got %b want 1", busy); end
      n_done = 0;
      for (int i = 1; i <= 13; i++) begin
         tick();
         if (done === 1'b1) n_done++;
      end
      exp_img = img(3);
      checks++; if (n_done !== 1) begin errors++; $display("FAIL rst_mid_l3_done: got %0d want 1", n_done); end
      checks++; if (mazestate !== exp_img) begin errors++; $display("FAIL rst_mid_l3_image: got %h want %h", mazestate, exp_img); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_level_latch();
`ifdef MAZE_EDIT_EN
      test_cursor();
      test_toggle();
      test_checkpoint();
`else
      test_no_edit();
`endif
      test_reset_midload();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/maze_state_writer.md
# maze_state_writer

- Produces and holds the 198-bit tile bitmap `mazestate` that the OLED maze renderer reads.
- The maze is 18 columns × 11 rows of 5×5-pixel tiles; tile index = col + 18·row.
- On request, loads one of four stored mazes row by row from a ROM.
- With editing compiled in, lets the player move a tile cursor and toggle tiles with debounced button pulses, without disturbing the checkpoint tiles.

## Interface
- No parameters; all geometry comes from the shared package.
- `CLK`  in  1  system clock; all logic sits on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `load_req`  in  1  single-cycle pulse; starts a maze load. Accepted only in IDLE.
- `level`  in  2  maze select (0–3), latched when `load_req` is accepted.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  single-cycle cursor move pulses.
- `btn_toggle`  in  1  single-cycle pulse; inverts the tile under the cursor.
- `mazestate`  out  198  tile bitmap; bit i = tile i; 1 = path/visible.
- `cursor_idx`  out  8  current cursor tile index, 0..197.
- `busy`  out  1  high while a load is in progress.
- `done`  out  1  one-cycle pulse when the last row has been written.

## Operation
- **Reset values**
  - `mazestate` = 0, `cursor_idx` = 0 (col 0, row 0), `busy` = 0, `done` = 0.
  - FSM goes to IDLE.
  - Reset mid-load aborts the load; partially written rows are cleared.
- **FSM states: IDLE, LOAD, FLUSH**
  - IDLE → LOAD on `load_req`: latch `level`, set row counter `rd_row` = 0.
  - LOAD: present {level, rd_row} to the ROM each cycle. Increment `rd_row` until it reaches 10, then go to FLUSH.
  - FLUSH: write the final row, pulse `done`, return to IDLE.
- **Row writes**
  - ROM data for row r lands in `mazestate[18r +: 18]`, with bit 0 of the ROM word = column 0.
  - Rows are written in order 0..10. Bits of rows not yet written keep their previous value.
- **Cursor** (editing build only; processed in IDLE only)
  - Tracked as col (5 bits, 0..17) and row (4 bits, 0..10). `cursor_idx` = col + 18·row.
  - Moves saturate at the edges; there is no wrap-around.
  - Simultaneous up+down cancel. Simultaneous left+right cancel.
  - A diagonal pair (e.g. up+right) applies both moves.
- **Toggle**
  - Inverts `mazestate[cursor_idx]` using the pre-move cursor when a move and a toggle arrive in the same cycle.
  - Toggles on the checkpoint tiles (31, 37, 113, 139, 178) are ignored.
- **During LOAD/FLUSH**
  - All button inputs and further `load_req` pulses are dropped, not queued.
- **Width rule**
  - Compute the index in 8 bits: 17 + 18·10 = 197 < 256.

## Timing
- ROM latency is 1 cycle (registered output).
- `load_req` sampled at edge E0 → `busy` = 1 after E0.
- Row k is written at edge E(k+2), so rows 0..10 are written at edges E2..E12.
- After E12: `done` = 1 for exactly one cycle and `busy` = 0.
- A new `load_req` can be accepted at E13 at the earliest.
- Cursor moves and toggles take effect on the edge after the pulse is sampled (1-cycle latency).
- `mazestate` and `cursor_idx` are registered outputs and never change combinationally.

## Configuration
- Macro: `MAZE_EDIT_EN`.
- **Defined:** cursor and toggle logic is built exactly as described above.
- **Undefined:**
  - The button inputs are unused.
  - `cursor_idx` is tied to 0.
  - `mazestate` changes only through reset and loads.

## Structure
- **Package `maze_pkg`** holds:
  - `MAZE_COLS` = 18, `MAZE_ROWS` = 11, `MAZE_TILES` = 198.
  - The five checkpoint index constants.
  - The FSM state enum.
- **Sub-module `maze_rom`** is natural:
  - Inputs: `CLK`, 2-bit level, 4-bit row. Output: registered 18-bit row word.
  - Holds 4 × 11 words; rows 11–15 return 0.

## Test plan
- **Reset then load.** Hold `RESET` for 2 cycles, then pulse `load_req` with `level` = 2 → `busy` for 12 cycles, `done` pulses once at E12, and `mazestate` equals the `maze_rom` level-2 image on all 198 bits.
- **Level latching.** Change `level` from 2 to 0 during the load → the loaded image is still level 2. A `load_req` pulsed at E5 is ignored (exactly one `done`).
- **Cursor saturation.** 20 `btn_right` then 15 `btn_down` → `cursor_idx` = 197. Then 25 `btn_left` and 12 `btn_up` → `cursor_idx` = 0.
- **Toggle.** Move to col 5, row 3 (idx 59) and toggle twice → bit 59 inverts, then restores. Same-cycle `btn_toggle` + `btn_right` at idx 59 → bit 59 flips and the cursor ends at 60.
- **Checkpoint protection.** Move to col 13, row 1 (idx 31) and toggle → bit 31 unchanged. Toggle at idx 32 → bit 32 flips.
- **Reset mid-load.** Assert `RESET` at E6 of a load → `mazestate` = 0, `busy` = 0, FSM in IDLE, no `done` pulse. The build without `MAZE_EDIT_EN` keeps `cursor_idx` = 0 under button stimulus.
